// File: rtl/tx_angulo_distancia_serial.sv
// tx_angulo_distancia_serial
// Serialises a captured angle word (three ASCII chars) and a 3-digit BCD
// distance as the 8-character message "AAA,DDD#" on an asynchronous line:
// start bit, 7 data bits LSB first, odd parity, 2 stop bits.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   partida      start request, sampled only in INICIAL
//   angulo       three ASCII chars [23:16],[15:8],[7:0]; low 7 bits sent
//   distancia    three BCD digits, MSD in [11:8]
//   saida_serial registered serial line, idles at 1
//   ocupado      high while a message is in flight
//   pronto       one-cycle completion pulse
//   db_estado    current FSM state, for debug
module tx_angulo_distancia_serial #(
    parameter int CICLOS_POR_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        partida,
    input  logic [23:0] angulo,
    input  logic [11:0] distancia,
    output logic        saida_serial,
    output logic        ocupado,
    output logic        pronto,
    output logic [2:0]  db_estado
);

    localparam int CW = (CICLOS_POR_BIT > 2) ? $clog2(CICLOS_POR_BIT) : 1;
    localparam logic [CW-1:0] ULTIMO_CICLO   = CW'(CICLOS_POR_BIT - 1);
    localparam logic [CW-1:0] PENULT_CICLO   = CW'(CICLOS_POR_BIT - 2);

    typedef enum logic [2:0] {
        INICIAL   = 3'd0,
        TRANSMITE = 3'd1,
        PROXIMO   = 3'd2,
        FINAL     = 3'd3
    } estado_t;

    estado_t       estado;
    logic [2:0]    car_idx;
    logic [3:0]    bit_idx;
    logic [CW-1:0] cnt;
    logic [9:0]    sr;        // remaining frame bits after the one on the line
    logic [20:0]   ang_r;     // only the transmitted 7 bits of each angle char
    logic [11:0]   dist_r;
    logic [6:0]    ch_sel;
    logic [9:0]    prox_quadro;

    // Only the low 7 bits of each angle byte are transmitted.
    logic unused_bits;
    assign unused_bits = ^{angulo[23], angulo[15], angulo[7]};

    function automatic logic [6:0] caractere(input logic [2:0]  i,
                                             input logic [20:0] a,
                                             input logic [11:0] d);
        case (i)
            3'd0:    return a[20:14];
            3'd1:    return a[13:7];
            3'd2:    return a[6:0];
            3'd3:    return 7'h2C;
            3'd4:    return 7'h30 + {3'b000, d[11:8]};
            3'd5:    return 7'h30 + {3'b000, d[7:4]};
            3'd6:    return 7'h30 + {3'b000, d[3:0]};
            default: return 7'h23;
        endcase
    endfunction

    // Character about to be loaded: char 0 straight from the inputs at
    // acceptance, otherwise the successor of the current character.
    always_comb begin
        if (estado == INICIAL)
            ch_sel = caractere(3'd0, {angulo[22:16], angulo[14:8], angulo[6:0]}, distancia);
        else
            ch_sel = caractere(car_idx + 3'd1, ang_r, dist_r);
        prox_quadro = {2'b11, ~^ch_sel, ch_sel};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= INICIAL;
            car_idx      <= '0;
            bit_idx      <= '0;
            cnt          <= '0;
            sr           <= '1;
            ang_r        <= '0;
            dist_r       <= '0;
            saida_serial <= 1'b1;
            ocupado      <= 1'b0;
            pronto       <= 1'b0;
        end else begin
            case (estado)
                INICIAL: begin
                    pronto       <= 1'b0;
                    saida_serial <= 1'b1;
                    if (partida) begin
                        ang_r        <= {angulo[22:16], angulo[14:8], angulo[6:0]};
                        dist_r       <= distancia;
                        car_idx      <= '0;
                        bit_idx      <= '0;
                        cnt          <= '0;
                        sr           <= prox_quadro;
                        saida_serial <= 1'b0;
                        ocupado      <= 1'b1;
                        estado       <= TRANSMITE;
                    end
                end

                TRANSMITE: begin
                    if (cnt == ULTIMO_CICLO) begin
                        cnt <= '0;
                        if (bit_idx == 4'd10) begin
                            // PROXIMO is folded into this edge so the next
                            // start bit follows the stop bit with no gap.
                            car_idx      <= car_idx + 3'd1;
                            bit_idx      <= '0;
                            sr           <= prox_quadro;
                            saida_serial <= 1'b0;
                        end else begin
                            bit_idx      <= bit_idx + 4'd1;
                            saida_serial <= sr[0];
                            sr           <= {1'b1, sr[9:1]};
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        // Enter FINAL one cycle early so that its registered
                        // outputs land exactly when the last stop bit ends.
                        if (car_idx == 3'd7 && bit_idx == 4'd10 && cnt == PENULT_CICLO)
                            estado <= FINAL;
                    end
                end

                FINAL: begin
                    pronto       <= 1'b1;
                    ocupado      <= 1'b0;
                    saida_serial <= 1'b1;
                    car_idx      <= '0;
                    bit_idx      <= '0;
                    cnt          <= '0;
                    estado       <= INICIAL;
                end

                default: estado <= INICIAL;
            endcase
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_tx_angulo_distancia_serial.sv
module tb_tx_angulo_distancia_serial;

    localparam int CPB = 4;
    localparam int MSG = 88 * CPB;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        partida = 1'b0;
    logic [23:0] angulo = '0;
    logic [11:0] distancia = '0;
    logic        saida_serial;
    logic        ocupado;
    logic        pronto;
    logic [2:0]  db_estado;

    always #5 clock = ~clock;

    tx_angulo_distancia_serial #(.CICLOS_POR_BIT(CPB)) dut (
        .clock        (clock),
        .reset        (reset),
        .partida      (partida),
        .angulo       (angulo),
        .distancia    (distancia),
        .saida_serial (saida_serial),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state: position inside the message (-1 = idle)
    int          mpos = -1;
    logic [87:0] mmsg = '0;
    int          cyc = 0;
    logic        cap [MSG];
    int          prontos = 0;
    int          pronto_cyc = 0;
    int          starts[$];
    logic        prev_oc = 1'b0;
    logic [6:0]  dch [8];
    logic        dpar [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] exp_char(input logic [23:0] a, input logic [11:0] d, input int j);
        int unsigned v;
        case (j)
            0: v = (a >> 16) & 127;
            1: v = (a >> 8) & 127;
            2: v = a & 127;
            3: v = 44;
            4: v = 48 + ((d >> 8) & 15);
            5: v = 48 + ((d >> 4) & 15);
            6: v = 48 + (d & 15);
            default: v = 35;
        endcase
        return 7'(v);
    endfunction

    function automatic logic [87:0] msg_bits(input logic [23:0] a, input logic [11:0] d);
        logic [87:0] m;
        logic [6:0]  c;
        int          ones;
        m = '0;
        for (int j = 0; j < 8; j++) begin
            c = exp_char(a, d, j);
            ones = 0;
            for (int b = 0; b < 7; b++) ones += int'(c[b]);
            m[j*11] = 1'b0;
            for (int b = 0; b < 7; b++) m[j*11+1+b] = c[b];
            m[j*11+8]  = (ones % 2 == 0);
            m[j*11+9]  = 1'b1;
            m[j*11+10] = 1'b1;
        end
        return m;
    endfunction

    // Model update on each rising edge, comparison on the following falling edge
    initial begin
        logic        r, p;
        logic [23:0] a;
        logic [11:0] d;
        logic        es, eo, ep;
        forever begin
            @(posedge clock);
            r = reset; p = partida; a = angulo; d = distancia;
            cyc++;
            if (r)
                mpos = -1;
            else if ((mpos == -1 || mpos == MSG) && p) begin
                mpos = 0;
                mmsg = msg_bits(a, d);
            end else if (mpos >= 0 && mpos < MSG)
                mpos++;
            else
                mpos = -1;

            @(negedge clock);
            if (mpos == -1) begin
                es = 1'b1; eo = 1'b0; ep = 1'b0;
            end else if (mpos < MSG) begin
                es = mmsg[mpos / CPB]; eo = 1'b1; ep = 1'b0;
            end else begin
                es = 1'b1; eo = 1'b0; ep = 1'b1;
            end
            chk("saida_serial", 32'(saida_serial), 32'(es));
            chk("ocupado", 32'(ocupado), 32'(eo));
            chk("pronto", 32'(pronto), 32'(ep));
            if (mpos == -1) chk("db_estado_idle", 32'(db_estado), 32'd0);
            if (mpos >= 0 && mpos < MSG) cap[mpos] = saida_serial;
            if (ocupado && !prev_oc) starts.push_back(cyc);
            prev_oc = ocupado;
            if (pronto) begin
                prontos++;
                pronto_cyc = cyc;
            end
        end
    end

    // Recover characters and parity bits from the captured line, mid-bit
    task automatic decode();
        for (int j = 0; j < 8; j++) begin
            for (int b = 0; b < 7; b++)
                dch[j][b] = cap[(j*11 + 1 + b) * CPB + CPB/2];
            dpar[j] = cap[(j*11 + 8) * CPB + CPB/2];
        end
    endtask

    task automatic send(input logic [23:0] a, input logic [11:0] d);
        @(posedge clock); #1;
        angulo = a; distancia = d; partida = 1'b1;
        @(posedge clock); #1;
        partida = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (mpos != -1 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("message_timeout", 32'(mpos == -1), 32'd1);
    endtask

    task automatic check_chars(input string nm, input logic [23:0] a, input logic [11:0] d);
        decode();
        for (int j = 0; j < 8; j++)
            chk(nm, 32'(dch[j]), 32'(exp_char(a, d, j)));
    endtask

    initial begin
        logic [87:0] m;
        logic [7:0]  exp2 [8];
        logic [7:0]  exp3 [8];
        logic [23:0] a0;
        logic [11:0] d0;
        int          ones;
        int          n;

        exp2 = '{8'h30, 8'h34, 8'h35, 8'h2C, 8'h31, 8'h32, 8'h33, 8'h23};
        exp3 = '{8'h37, 8'h3F, 8'h00, 8'h2C, 8'h30, 8'h30, 8'h30, 8'h23};

        // Hand-computed pins on the model itself
        m = msg_bits(24'h303435, 12'h123);
        chk("model_frame_30", 32'(m[10:0]), 32'(11'b111_0110000_0));
        m = msg_bits(24'h373F00, 12'h000);
        chk("model_par_37", 32'(m[8]), 32'd0);
        chk("model_par_3F", 32'(m[19]), 32'd1);
        chk("model_par_00", 32'(m[30]), 32'd1);

        // 1: reset then idle
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("reset_saida", 32'(saida_serial), 32'd1);
        chk("reset_ocupado", 32'(ocupado), 32'd0);
        chk("reset_pronto", 32'(pronto), 32'd0);
        chk("reset_estado", 32'(db_estado), 32'd0);

        // 2: nominal message
        prontos = 0; starts.delete();
        send(24'h303435, 12'h123);
        wait_idle();
        decode();
        for (int j = 0; j < 8; j++) chk("nominal_byte", 32'(dch[j]), 32'(exp2[j]));
        chk("nominal_pronto_count", 32'(prontos), 32'd1);
        if (starts.size() > 0)
            chk("nominal_pronto_latency", 32'(pronto_cyc - starts[0]), 32'd352);
        else
            chk("nominal_start_seen", 32'(starts.size()), 32'd1);

        // 3: parity coverage
        send(24'h373F00, 12'h000);
        wait_idle();
        decode();
        for (int j = 0; j < 8; j++) chk("parity_byte", 32'(dch[j]), 32'(exp3[j]));
        chk("parity_37", 32'(dpar[0]), 32'd0);
        chk("parity_3F", 32'(dpar[1]), 32'd1);
        chk("parity_00", 32'(dpar[2]), 32'd1);
        for (int j = 0; j < 8; j++) begin
            ones = int'(dpar[j]);
            for (int b = 0; b < 7; b++) ones += int'(dch[j][b]);
            chk("parity_odd", 32'(ones % 2), 32'd1);
        end

        // 4: inputs changed and partida pulsed mid-message
        prontos = 0;
        a0 = 24'($urandom); d0 = 12'($urandom);
        send(a0, d0);
        repeat (99) @(posedge clock);
        #1;
        angulo = 24'($urandom); distancia = 12'($urandom); partida = 1'b1;
        @(posedge clock); #1;
        partida = 1'b0;
        wait_idle();
        check_chars("stable_char", a0, d0);
        chk("stable_pronto_count", 32'(prontos), 32'd1);

        // 5: reset mid-message, then a fresh message
        prontos = 0;
        send(24'($urandom), 12'($urandom));
        repeat (149) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        chk("abort_saida", 32'(saida_serial), 32'd1);
        chk("abort_ocupado", 32'(ocupado), 32'd0);
        repeat (10) @(posedge clock);
        chk("abort_no_pronto", 32'(prontos), 32'd0);
        a0 = 24'($urandom); d0 = 12'($urandom);
        send(a0, d0);
        wait_idle();
        check_chars("after_abort_char", a0, d0);
        chk("after_abort_pronto", 32'(prontos), 32'd1);

        // 6: partida held high, three back-to-back messages
        prontos = 0; starts.delete();
        @(posedge clock); #1;
        angulo = 24'($urandom); distancia = 12'($urandom); partida = 1'b1;
        n = 0;
        while (starts.size() < 3 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        partida = 1'b0;
        chk("b2b_three_starts", 32'(starts.size() >= 3), 32'd1);
        wait_idle();
        chk("b2b_pronto_count", 32'(prontos), 32'd3);
        if (starts.size() >= 3) begin
            chk("b2b_gap_1", 32'(starts[1] - starts[0]), 32'd353);
            chk("b2b_gap_2", 32'(starts[2] - starts[1]), 32'd353);
        end

        // Random messages, including BCD digits above 9
        for (int k = 0; k < 3; k++) begin
            prontos = 0;
            a0 = 24'($urandom); d0 = 12'($urandom);
            send(a0, d0);
            wait_idle();
            check_chars("random_char", a0, d0);
            chk("random_pronto", 32'(prontos), 32'd1);
        end

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
